// File: rtl/param_datapath_pkg.sv
// Shared enums for param_datapath: ALU ops, B-operand shifts, writeback sources, FSM states.
package param_datapath_pkg;

    typedef enum logic [1:0] {
        OP_ADD  = 2'd0,
        OP_SUB  = 2'd1,
        OP_AND  = 2'd2,
        OP_NOTB = 2'd3
    } alu_op_e;

    typedef enum logic [1:0] {
        SH_NONE = 2'd0,
        SH_LSL1 = 2'd1,
        SH_LSR1 = 2'd2,
        SH_ASR1 = 2'd3
    } shift_e;

    typedef enum logic [1:0] {
        WB_ALU = 2'd0,
        WB_PC  = 2'd1,
        WB_IMM = 2'd2,
        WB_MEM = 2'd3
    } wsel_e;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RDA  = 3'd1,
        S_RDB  = 3'd2,
        S_EXEC = 3'd3,
        S_WB   = 3'd4
    } state_e;

endpackage

// File: rtl/pdp_regfile.sv
// Register file for param_datapath: one write port, one asynchronous read port, async clear.
module pdp_regfile #(
    parameter int  WIDTH = 16,
    parameter int  NREGS = 8,
    localparam int RW    = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_we,
    input  logic [RW-1:0]    i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic [RW-1:0]    i_raddr,
    output logic [WIDTH-1:0] o_rdata
);

    logic [WIDTH-1:0] r_mem [NREGS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/param_datapath.sv
// Multi-cycle register/ALU datapath: IDLE->RDA->RDB->EXEC->WB, one command per 5 cycles.
// Optional macro PARAM_DATAPATH_ASR_EN makes shift code 3 an arithmetic right shift.
module param_datapath
    import param_datapath_pkg::*;
#(
    parameter int  WIDTH = 16,
    parameter int  NREGS = 8,
    parameter int  PCW   = 9,
    localparam int RW    = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [RW-1:0]    cmd_rn,
    input  logic [RW-1:0]    cmd_rm,
    input  logic [RW-1:0]    cmd_rd,
    input  logic [1:0]       cmd_shift,
    input  logic             cmd_asel,
    input  logic             cmd_bsel,
    input  logic [WIDTH-1:0] cmd_imm,
    input  logic [1:0]       cmd_wsel,
    input  logic             cmd_setf,
    input  logic [WIDTH-1:0] mdata,
    input  logic [PCW-1:0]   pc,
    output logic             res_valid,
    output logic [WIDTH-1:0] res_data,
    output logic [2:0]       status,
    output logic [2:0]       o_dbg_state
);

    // Handshake: a command transfers on the rising edge where cmd_valid && cmd_ready;
    // cmd_ready is high only in IDLE and cmd_* are don't-care in every other state.
    state_e           r_state, w_next;
    alu_op_e          r_op;
    shift_e           r_shift;
    wsel_e            r_wsel;
    logic [RW-1:0]    r_rn, r_rm, r_rd;
    logic             r_asel, r_bsel, r_setf;
    logic [WIDTH-1:0] r_imm, r_a, r_b, r_c, r_res_data;
    logic [2:0]       r_status;

    logic             w_ready, w_wb_en, w_accept, w_v;
    logic [RW-1:0]    w_raddr;
    logic [WIDTH-1:0] w_rdata, w_a, w_bsh, w_b, w_alu, w_wb_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next  = r_state;
        w_ready = 1'b0;
        w_wb_en = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_ready = 1'b1;
                if (cmd_valid) w_next = S_RDA;
            end
            S_RDA:  w_next = S_RDB;
            S_RDB:  w_next = S_EXEC;
            S_EXEC: w_next = S_WB;
            S_WB: begin
                w_wb_en = 1'b1;
                w_next  = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    assign w_accept = cmd_valid && w_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op    <= OP_ADD;
            r_shift <= SH_NONE;
            r_wsel  <= WB_ALU;
            r_rn    <= '0;
            r_rm    <= '0;
            r_rd    <= '0;
            r_asel  <= 1'b0;
            r_bsel  <= 1'b0;
            r_setf  <= 1'b0;
            r_imm   <= '0;
        end else if (w_accept) begin
            r_op    <= alu_op_e'(cmd_op);
            r_shift <= shift_e'(cmd_shift);
            r_wsel  <= wsel_e'(cmd_wsel);
            r_rn    <= cmd_rn;
            r_rm    <= cmd_rm;
            r_rd    <= cmd_rd;
            r_asel  <= cmd_asel;
            r_bsel  <= cmd_bsel;
            r_setf  <= cmd_setf;
            r_imm   <= cmd_imm;
        end
    end

    // The single read port serves rn in RDA and rm in RDB.
    assign w_raddr = (r_state == S_RDA) ? r_rn : r_rm;

    pdp_regfile #(
        .WIDTH (WIDTH),
        .NREGS (NREGS)
    ) u_regfile (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_we    (w_wb_en),
        .i_waddr (r_rd),
        .i_wdata (w_wb_data),
        .i_raddr (w_raddr),
        .o_rdata (w_rdata)
    );

    always_comb begin
        w_a = r_asel ? '0 : r_a;
        case (r_shift)
            SH_LSL1: w_bsh = {r_b[WIDTH-2:0], 1'b0};
            SH_LSR1: w_bsh = {1'b0, r_b[WIDTH-1:1]};
`ifdef PARAM_DATAPATH_ASR_EN
            SH_ASR1: w_bsh = {r_b[WIDTH-1], r_b[WIDTH-1:1]};
`else
            SH_ASR1: w_bsh = {1'b0, r_b[WIDTH-1:1]};
`endif
            default: w_bsh = r_b;
        endcase
        w_b = r_bsel ? r_imm : w_bsh;
        w_v = 1'b0;
        case (r_op)
            OP_ADD: begin
                w_alu = w_a + w_b;
                w_v   = (w_a[WIDTH-1] == w_b[WIDTH-1]) && (w_alu[WIDTH-1] != w_a[WIDTH-1]);
            end
            OP_SUB: begin
                w_alu = w_a - w_b;
                w_v   = (w_a[WIDTH-1] != w_b[WIDTH-1]) && (w_alu[WIDTH-1] != w_a[WIDTH-1]);
            end
            OP_AND:  w_alu = w_a & w_b;
            default: w_alu = ~w_b;
        endcase
    end

    always_comb begin
        case (r_wsel)
            WB_PC:   w_wb_data = WIDTH'(pc);
            WB_IMM:  w_wb_data = r_imm;
            WB_MEM:  w_wb_data = mdata;
            default: w_wb_data = r_c;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a        <= '0;
            r_b        <= '0;
            r_c        <= '0;
            r_status   <= '0;
            r_res_data <= '0;
        end else begin
            if (r_state == S_RDA) r_a <= w_rdata;
            if (r_state == S_RDB) r_b <= w_rdata;
            if (r_state == S_EXEC) begin
                r_c <= w_alu;
                if (r_setf) r_status <= {(w_alu == '0), w_alu[WIDTH-1], w_v};
            end
            if (w_wb_en) r_res_data <= w_wb_data;
        end
    end

    assign cmd_ready   = w_ready;
    assign res_valid   = w_wb_en;
    assign res_data    = w_wb_en ? w_wb_data : r_res_data;
    assign status      = r_status;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_param_datapath.sv
// Self-checking bench for param_datapath: directed scenarios plus random commands
// scored against an arithmetic reference model through an expected-result queue.
module tb_param_datapath;

    localparam int W  = 16;
    localparam int N  = 8;
    localparam int P  = 9;
    localparam int RW = 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [1:0]    cmd_op;
    logic [RW-1:0] cmd_rn, cmd_rm, cmd_rd;
    logic [1:0]    cmd_shift;
    logic          cmd_asel, cmd_bsel;
    logic [W-1:0]  cmd_imm;
    logic [1:0]    cmd_wsel;
    logic          cmd_setf;
    logic [W-1:0]  mdata;
    logic [P-1:0]  pc;
    logic          res_valid;
    logic [W-1:0]  res_data;
    logic [2:0]    status;
    logic [2:0]    o_dbg_state;

    param_datapath #(.WIDTH(W), .NREGS(N), .PCW(P)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_op      (cmd_op),
        .cmd_rn      (cmd_rn),
        .cmd_rm      (cmd_rm),
        .cmd_rd      (cmd_rd),
        .cmd_shift   (cmd_shift),
        .cmd_asel    (cmd_asel),
        .cmd_bsel    (cmd_bsel),
        .cmd_imm     (cmd_imm),
        .cmd_wsel    (cmd_wsel),
        .cmd_setf    (cmd_setf),
        .mdata       (mdata),
        .pc          (pc),
        .res_valid   (res_valid),
        .res_data    (res_data),
        .status      (status),
        .o_dbg_state (o_dbg_state)
    );

    // ---------------- clock / cycle counter ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard state ----------------
    logic [W-1:0] exp_q[$];
    logic [2:0]   exp_st_q[$];
    int           exp_cyc_q[$];

    int     checks   = 0;
    int     failures = 0;
    logic   mon_en   = 1'b0;
    logic   acc_valid = 1'b0;
    int     last_acc = 0;

    logic [W-1:0] m_rf [N];
    logic [2:0]   m_st;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < N; i++) m_rf[i] = '0;
        m_st = '0;
    endtask

    // Reference model: computes one command from the architectural rules.
    task automatic model_exec(input logic [1:0] op, input logic [RW-1:0] rn, rm, rd,
                              input logic [1:0] sh, input logic as, bs,
                              input logic [W-1:0] imm, input logic [1:0] ws, input logic sf,
                              output logic [W-1:0] wdata);
        logic [W-1:0] a, b, bv, r;
        longint       sa, sb, sr, smax, smin;
        logic         v;
        a  = as ? '0 : m_rf[rn];
        bv = m_rf[rm];
        case (sh)
            2'd0: b = bv;
            2'd1: b = W'(bv * 2);
            2'd2: b = bv / 2;
`ifdef PARAM_DATAPATH_ASR_EN
            default: b = W'($signed(bv) >>> 1);
`else
            default: b = bv / 2;
`endif
        endcase
        if (bs) b = imm;
        sa   = longint'($signed(a));
        sb   = longint'($signed(b));
        smax = (longint'(1) <<< (W - 1)) - 1;
        smin = -(longint'(1) <<< (W - 1));
        v    = 1'b0;
        case (op)
            2'd0: begin sr = sa + sb; r = W'(sr); v = (sr > smax) || (sr < smin); end
            2'd1: begin sr = sa - sb; r = W'(sr); v = (sr > smax) || (sr < smin); end
            2'd2: r = a & b;
            default: r = ~b;
        endcase
        if (sf) m_st = {(r == '0), r[W-1], v};
        case (ws)
            2'd0: wdata = r;
            2'd1: wdata = W'(pc);
            2'd2: wdata = imm;
            default: wdata = mdata;
        endcase
        m_rf[rd] = wdata;
    endtask

    // ---------------- monitor ----------------
    logic exp_v, exp_rdy;
    always @(negedge clk) begin
        if (mon_en) begin
            if (exp_cyc_q.size() > 0 && exp_cyc_q[0] < cyc) begin
                checks++;
                failures++;
                $display("FAIL res_missing: no result seen, expected in cycle %0d (now %0d)", exp_cyc_q[0], cyc);
                void'(exp_q.pop_front());
                void'(exp_st_q.pop_front());
                void'(exp_cyc_q.pop_front());
            end
            exp_v   = (exp_cyc_q.size() > 0) && (exp_cyc_q[0] == cyc);
            exp_rdy = !(acc_valid && (cyc <= last_acc + 3));
            chk("res_valid", res_valid, exp_v);
            chk("cmd_ready", cmd_ready, exp_rdy);
            if (exp_v && res_valid) begin
                chk("res_data", res_data, exp_q.pop_front());
                chk("status", status, exp_st_q.pop_front());
                void'(exp_cyc_q.pop_front());
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send_cmd(input logic [1:0] op, input logic [RW-1:0] rn, rm, rd,
                            input logic [1:0] sh, input logic as, bs,
                            input logic [W-1:0] imm, input logic [1:0] ws, input logic sf,
                            input logic hold);
        logic         seen, accepted;
        logic [W-1:0] wd;
        int           waited;
        cmd_op = op; cmd_rn = rn; cmd_rm = rm; cmd_rd = rd; cmd_shift = sh;
        cmd_asel = as; cmd_bsel = bs; cmd_imm = imm; cmd_wsel = ws; cmd_setf = sf;
        cmd_valid = 1'b1;
        accepted = 1'b0;
        waited = 0;
        while (!accepted && waited < 20) begin
            seen = cmd_ready;
            @(posedge clk);
            #1;
            waited++;
            if (seen) accepted = 1'b1;
        end
        if (!accepted) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout: command not accepted within 20 cycles");
            cmd_valid = 1'b0;
        end else begin
            model_exec(op, rn, rm, rd, sh, as, bs, imm, ws, sf, wd);
            exp_q.push_back(wd);
            exp_st_q.push_back(m_st);
            exp_cyc_q.push_back(cyc + 3);
            last_acc  = cyc;
            acc_valid = 1'b1;
            if (!hold) cmd_valid = 1'b0;
        end
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL done_timeout: %0d results outstanding", exp_q.size());
        end
    endtask

    task automatic load_imm(input logic [RW-1:0] rd, input logic [W-1:0] v);
        send_cmd(2'd0, 3'd0, 3'd0, rd, 2'd0, 1'b0, 1'b0, v, 2'd2, 1'b0, 1'b0);
        wait_done();
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        exp_q.delete();
        exp_st_q.delete();
        exp_cyc_q.delete();
        acc_valid = 1'b0;
        cmd_valid = 1'b0;
        model_clear();
    endtask

    // ---------------- main sequence ----------------
    initial begin
        cmd_op = '0; cmd_rn = '0; cmd_rm = '0; cmd_rd = '0; cmd_shift = '0;
        cmd_asel = 1'b0; cmd_bsel = 1'b0; cmd_imm = '0; cmd_wsel = '0; cmd_setf = 1'b0;
        mdata = 16'h1357; pc = 9'h0A5;
        apply_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_cmd_ready", cmd_ready, 1'b1);
        chk("rst_res_valid", res_valid, 1'b0);
        chk("rst_res_data", res_data, 16'h0000);
        chk("rst_status", status, 3'b000);
        chk("rst_state", o_dbg_state, 3'd0);
        rst_n = 1'b1;
        mon_en = 1'b1;

        // Immediate write to r1, then read it back through the ALU.
        load_imm(3'd1, 16'h0005);
        send_cmd(2'd0, 3'd0, 3'd1, 3'd6, 2'd0, 1'b1, 1'b0, 16'h0, 2'd0, 1'b0, 1'b0);
        wait_done();

        // Signed overflow on ADD.
        load_imm(3'd1, 16'h7FFF);
        load_imm(3'd2, 16'h0001);
        send_cmd(2'd0, 3'd1, 3'd2, 3'd3, 2'd0, 1'b0, 1'b0, 16'h0, 2'd0, 1'b1, 1'b0);
        wait_done();

        // SUB to zero sets Z; AND without setf leaves status alone.
        send_cmd(2'd1, 3'd3, 3'd3, 3'd3, 2'd0, 1'b0, 1'b0, 16'h0, 2'd0, 1'b1, 1'b0);
        wait_done();
        send_cmd(2'd2, 3'd1, 3'd2, 3'd4, 2'd0, 1'b0, 1'b0, 16'h0, 2'd0, 1'b0, 1'b0);
        wait_done();

        // Shift code 3 on a negative B.
        load_imm(3'd4, 16'h8002);
        send_cmd(2'd0, 3'd0, 3'd4, 3'd5, 2'd3, 1'b1, 1'b0, 16'h0, 2'd0, 1'b0, 1'b0);
        wait_done();

        // Other writeback sources and rd==rn.
        send_cmd(2'd3, 3'd5, 3'd5, 3'd5, 2'd1, 1'b0, 1'b0, 16'h0, 2'd1, 1'b1, 1'b0);
        wait_done();
        send_cmd(2'd0, 3'd5, 3'd5, 3'd5, 2'd0, 1'b0, 1'b0, 16'h0, 2'd3, 1'b1, 1'b0);
        wait_done();

        // Reset in the middle of EXEC discards the command.
        send_cmd(2'd0, 3'd0, 3'd0, 3'd6, 2'd0, 1'b0, 1'b0, 16'h1234, 2'd2, 1'b1, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("exec_state", o_dbg_state, 3'd3);
        apply_reset();
        #1;
        chk("midrst_cmd_ready", cmd_ready, 1'b1);
        chk("midrst_res_valid", res_valid, 1'b0);
        chk("midrst_res_data", res_data, 16'h0000);
        chk("midrst_status", status, 3'b000);
        @(posedge clk); #1;
        chk("midrst_next_ready", cmd_ready, 1'b1);
        chk("midrst_next_valid", res_valid, 1'b0);
        rst_n = 1'b1;
        send_cmd(2'd0, 3'd0, 3'd6, 3'd7, 2'd0, 1'b1, 1'b0, 16'h0, 2'd0, 1'b0, 1'b0);
        wait_done();

        // Back-to-back dependent commands with cmd_valid held high.
        load_imm(3'd1, 16'h0100);
        load_imm(3'd2, 16'h0023);
        send_cmd(2'd0, 3'd1, 3'd2, 3'd5, 2'd0, 1'b0, 1'b0, 16'h0, 2'd0, 1'b1, 1'b1);
        send_cmd(2'd1, 3'd5, 3'd2, 3'd6, 2'd1, 1'b0, 1'b0, 16'h0, 2'd0, 1'b1, 1'b1);
        send_cmd(2'd0, 3'd6, 3'd5, 3'd6, 2'd0, 1'b0, 1'b1, 16'hFFF0, 2'd0, 1'b1, 1'b0);
        wait_done();

        // Randomized commands.
        for (int i = 0; i < 60; i++) begin
            mdata = 16'($urandom);
            pc    = 9'($urandom);
            send_cmd(2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                     3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 1)), 16'($urandom), 2'($urandom_range(0, 3)),
                     1'($urandom_range(0, 1)), 1'b0);
            if (($urandom_range(0, 3) == 0)) wait_done();
            else begin
                wait_done();
                repeat ($urandom_range(0, 2)) begin
                    @(posedge clk);
                    #1;
                end
            end
        end

        repeat (3) @(posedge clk);
        #1;
        mon_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/param_datapath.md
PARAM_DATAPATH -- requirements
Module: param_datapath

Interface
REQ-001 SHALL have parameter WIDTH, default 16, meaning datapath and register width in bits (legal range 8..64).
REQ-002 SHALL have parameter NREGS, default 8, meaning register-file entry count (power of two, 2..32); RW = log2(NREGS).
REQ-003 SHALL have parameter PCW, default 9, meaning PC input width (PCW <= WIDTH).
REQ-004 SHALL have port clk  in  1  sole clock; all state updates on rising edge.
REQ-005 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have ports cmd_valid in 1 and cmd_ready out 1, the command handshake.
REQ-007 SHALL have port cmd_op  in  2  ALU op: 0 ADD, 1 SUB (A-B), 2 AND, 3 NOT B.
REQ-008 SHALL have ports cmd_rn, cmd_rm, cmd_rd  in  RW  meaning A-source, B-source and destination register indices.
REQ-009 SHALL have port cmd_shift  in  2  B-operand shift: 0 none, 1 LSL1, 2 LSR1, 3 ASR1.
REQ-010 SHALL have ports cmd_asel in 1 (1 forces A operand to 0) and cmd_bsel in 1 (1 selects cmd_imm as B, unshifted).
REQ-011 SHALL have port cmd_imm  in  WIDTH  pre-sign-extended immediate.
REQ-012 SHALL have port cmd_wsel  in  2  writeback source: 0 ALU result, 1 pc zero-extended, 2 cmd_imm, 3 mdata.
REQ-013 SHALL have port cmd_setf  in  1  meaning update status on this command.
REQ-014 SHALL have ports mdata in WIDTH (memory read data) and pc in PCW (program counter).
REQ-015 SHALL have ports res_valid out 1, res_data out WIDTH (value written back) and status out 3 as {Z,N,V}.

Function
REQ-016 SHALL implement FSM IDLE->RDA->RDB->EXEC->WB->IDLE, with exactly one state per cycle after acceptance.
REQ-017 SHALL assert cmd_ready only in IDLE, accept a command on cmd_valid&&cmd_ready, and latch all cmd_* fields at acceptance; cmd_* SHALL be ignored elsewhere.
REQ-018 SHALL load operand register A from rf[rn] in RDA and operand register B from rf[rm] in RDB.
REQ-019 SHALL compute the ALU result in EXEC into result register C, truncating to WIDTH and discarding carry.
REQ-020 SHALL, in EXEC when setf=1, load Z=(C==0), N=C[WIDTH-1], and V=signed overflow for ADD/SUB (0 for AND/NOT); status SHALL hold otherwise.
REQ-021 SHALL, in WB, write the wsel-selected value to rf[rd] at the WB-exit edge, hold res_valid=1 for exactly that one cycle, and drive res_data to the written value; res_data SHALL hold between commands.
REQ-022 SHALL have latency such that acceptance at edge k gives res_valid high during the cycle after edge k+3, for a throughput of one command per 5 cycles.
REQ-023 SHALL ensure a command reading rd of the preceding command observes the new value (no stale read).
REQ-024 SHALL, when rn==rm, give both operands the same register value; when rd==rn, the write SHALL occur after the read.

Reset
REQ-025 SHALL, on rst_n low at any time (including mid-command), immediately set state IDLE, cmd_ready=1, res_valid=0, res_data=0, status=0, A/B/C=0 and all register-file entries to 0, discarding any in-flight command.

Configuration
REQ-026 SHALL, with macro PARAM_DATAPATH_ASR_EN defined, make shift 3 an arithmetic right shift (MSB replicated).
REQ-027 SHALL, without PARAM_DATAPATH_ASR_EN, make shift 3 behave identically to LSR1.

Structure
REQ-028 SHALL place ALU-op, shift, wsel and FSM-state enums in shared package param_datapath_pkg.
REQ-029 SHALL implement the register file as sub-module pdp_regfile (WIDTH, NREGS; one write port, one read port, async reset).

Verification
REQ-030 SHALL cover: reset, then write via wsel=2 imm=0x0005 to r1 -> res_valid after 5 cycles, res_data=0x0005, rf[1]=5.
REQ-031 SHALL cover: ADD r1(0x7FFF)+r2(0x0001), setf=1 -> res_data=0x8000, status={Z0,N1,V1}.
REQ-032 SHALL cover: SUB r3-r3, setf=1 -> res_data=0, Z=1; then AND with setf=0 -> status unchanged.
REQ-033 SHALL cover: shift=3 on B=0x8002 -> 0xC001 with PARAM_DATAPATH_ASR_EN, 0x4001 without.
REQ-034 SHALL cover: rst_n pulsed low during EXEC -> next cycle cmd_ready=1, no res_valid, rd still 0.
REQ-035 SHALL cover: back-to-back dependent commands with cmd_valid held high -> cmd_ready high only in IDLE and the second command reads the first result.
